// File: rtl/fp_pkg.sv
// Shared constants, FSM encoding and IEEE-754 single-precision helpers for the
// sequential FP multiplier and its rounding stage.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [FRAC_W:0]  mant;   // hidden bit included
    } fp_unpk_t;

    function automatic logic is_nan(input logic [31:0] f);
        return (&f[30:23]) && (|f[22:0]);
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (&f[30:23]) && !(|f[22:0]);
    endfunction

    // Denormals count as zero: inputs are flushed.
    function automatic logic is_zero(input logic [31:0] f);
        return !(|f[30:23]);
    endfunction

    function automatic fp_unpk_t unpack(input logic [31:0] f);
        fp_unpk_t u;
        u.sign = f[31];
        u.exp  = f[30:23];
        u.mant = {1'b1, f[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Combinational normalise + round-to-nearest-even + overflow/underflow packing
// for a 48-bit mantissa product with a 10-bit signed biased exponent.
module fp_mul_round
    import fp_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  exp_in,
    input  logic [47:0]        prod,
    output logic [31:0]        result,
    output logic [3:0]         flags
);

    logic [23:0]       mant;
    logic              guard;
    logic              sticky;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic signed [9:0] e;

    always_comb begin
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            e      = exp_in + 10'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            e      = exp_in;
        end

        mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
        // A carry out of rounding leaves 1.000..0, so only the exponent moves.
        if (mant_r[24]) begin
            frac = mant_r[23:1];
            e    = e + 10'sd1;
        end else begin
            frac = mant_r[22:0];
        end

        flags          = 4'h0;
        flags[FLG_INX] = guard | sticky;
        result         = {sign, e[7:0], frac};

        if (e >= 10'sd255) begin
            result         = {sign, POS_INF[30:0]};
            flags[FLG_OVF] = 1'b1;
            flags[FLG_INX] = 1'b1;
        end else if (e <= 10'sd0) begin
            result         = {sign, 31'd0};
            flags[FLG_UNF] = 1'b1;
            flags[FLG_INX] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 single multiplier: shift-add mantissa datapath, one result in flight.
// Define FP_MUL_RADIX4_EN for 2 multiplier bits per cycle (12 iterations instead of 24).
module fp_mul_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] float_a,
    input  logic [31:0] float_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);

`ifdef FP_MUL_RADIX4_EN
    localparam int ITERS = (FRAC_W + 1) / 2;
`else
    localparam int ITERS = FRAC_W + 1;
`endif
    localparam logic [4:0] LAST = 5'(ITERS - 1);

    state_t            state, state_n;
    logic [47:0]       acc, acc_n;
    logic [23:0]       mcand;
    logic [4:0]        cnt;
    logic              sgn;
    logic signed [9:0] exp_r;

    fp_unpk_t    ua, ub;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic [3:0]  spec_flg;
    logic [31:0] rnd_result;
    logic [3:0]  rnd_flags;

    assign ua = unpack(float_a);
    assign ub = unpack(float_b);

    always_comb begin
        spec_hit = 1'b1;
        spec_res = 32'h0;
        spec_flg = 4'h0;
        if (is_nan(float_a) || is_nan(float_b)) begin
            spec_res          = QNAN;
            spec_flg[FLG_INV] = 1'b1;
        end else if ((is_inf(float_a) && is_zero(float_b)) ||
                     (is_zero(float_a) && is_inf(float_b))) begin
            spec_res          = QNAN;
            spec_flg[FLG_INV] = 1'b1;
        end else if (is_inf(float_a) || is_inf(float_b)) begin
            spec_res = {ua.sign ^ ub.sign, POS_INF[30:0]};
        end else if (is_zero(float_a) || is_zero(float_b)) begin
            spec_res = {ua.sign ^ ub.sign, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // The multiplier sits in the low half of acc and is consumed from the LSB
    // as product bits shift in from above.
`ifdef FP_MUL_RADIX4_EN
    logic [25:0] mcand3;
    logic [25:0] addend;
    logic [25:0] sum;

    always_comb begin
        addend = 26'd0;
        case (acc[1:0])
            2'd1:    addend = {2'b00, mcand};
            2'd2:    addend = {1'b0, mcand, 1'b0};
            2'd3:    addend = mcand3;
            default: addend = 26'd0;
        endcase
        sum   = {2'b00, acc[47:24]} + addend;
        acc_n = {sum, acc[23:2]};
    end
`else
    logic [24:0] sum;

    always_comb begin
        sum   = {1'b0, acc[47:24]} + (acc[0] ? {1'b0, mcand} : 25'd0);
        acc_n = {sum, acc[23:1]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_n = spec_hit ? DONE : MUL;
            MUL:     if (cnt == LAST) state_n = ROUND;
            ROUND:   state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= 48'd0;
            mcand  <= 24'd0;
            cnt    <= 5'd0;
            sgn    <= 1'b0;
            exp_r  <= 10'sd0;
            result <= 32'h0;
            flags  <= 4'h0;
`ifdef FP_MUL_RADIX4_EN
            mcand3 <= 26'd0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mcand <= ua.mant;
                    acc   <= {24'd0, ub.mant};
                    cnt   <= 5'd0;
                    sgn   <= ua.sign ^ ub.sign;
                    exp_r <= {2'b00, ua.exp} + {2'b00, ub.exp} - 10'(BIAS);
`ifdef FP_MUL_RADIX4_EN
                    mcand3 <= {2'b00, ua.mant} + {1'b0, ua.mant, 1'b0};
`endif
                    if (spec_hit) begin
                        result <= spec_res;
                        flags  <= spec_flg;
                    end
                end
                MUL: begin
                    acc <= acc_n;
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    result <= rnd_result;
                    flags  <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    fp_mul_round u_round (
        .sign   (sgn),
        .exp_in (exp_r),
        .prod   (acc),
        .result (rnd_result),
        .flags  (rnd_flags)
    );

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed vector table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] float_a;
    logic [31:0] float_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

`ifdef FP_MUL_RADIX4_EN
    localparam int LAT = 14;
`else
    localparam int LAT = 26;
`endif

    fp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .float_a   (float_a),
        .float_b   (float_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, scaled to a 24-bit mantissa, RNE by remainder.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e, sh;
        longint fa, fb, p, q, rem, half;
        logic   s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inx;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        s  = a[31] ^ b[31];
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return {4'b1000, 32'h7FC00000};
        if ((a_inf && b_zero) || (a_zero && b_inf)) return {4'b1000, 32'h7FC00000};
        if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {4'b0000, s, 31'd0};
        p  = (fa + 64'sd8388608) * (fb + 64'sd8388608);
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'sd1 <<< 47)) begin
            sh = 24;
            e++;
        end
        q    = p >>> sh;
        rem  = p - (q <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'sd1 <<< 24)) begin
            q = q >>> 1;
            e++;
        end
        inx = (rem != 0);
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        return {3'b000, inx, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic is_spec(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0]  ex;
        logic [22:0] fr;
        int          kind;
        kind = int'($urandom_range(0, 15));
        fr   = 23'($urandom);
        case (kind)
            0:       ex = 8'h00;
            1:       begin ex = 8'hFF; fr = 23'd0; end
            2:       begin ex = 8'hFF; fr = fr | 23'd1; end
            3:       ex = 8'($urandom_range(200, 254));
            4:       ex = 8'($urandom_range(1, 60));
            default: ex = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom_range(0, 1)), ex, fr};
    endfunction

    // Issue one operation, hold out_ready low for 'stall' cycles once valid appears.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        float_a   = a;
        float_b   = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 200);
        chk("timeout", 32'(out_valid), 32'd1);
        repeat (stall) @(negedge clk);
        r = result;
        f = flags;
        out_ready = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic [35:0] m;
        logic        saw;
        int          lat, n, st;
        logic [31:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        float_a = 32'h0; float_b = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    result,         32'h0);
        chk("rst_flags",     32'(flags),     32'h0);
        rst = 1'b0;

        vecs.push_back('{a:32'h40E00000, b:32'hC0400000, res:32'hC1A80000, flg:4'b0000, lat:LAT});
        vecs.push_back('{a:32'h3F800001, b:32'h3F800001, res:32'h3F800002, flg:4'b0001, lat:LAT});
        vecs.push_back('{a:32'h7F800000, b:32'h00000000, res:32'h7FC00000, flg:4'b1000, lat:1});
        vecs.push_back('{a:32'h7F800000, b:32'h40000000, res:32'h7F800000, flg:4'b0000, lat:1});
        vecs.push_back('{a:32'h7F7FFFFF, b:32'h40000000, res:32'h7F800000, flg:4'b0101, lat:LAT});
        vecs.push_back('{a:32'h00800000, b:32'h00800000, res:32'h00000000, flg:4'b0011, lat:LAT});
        vecs.push_back('{a:32'h7FC00000, b:32'h3F800000, res:32'h7FC00000, flg:4'b1000, lat:1});
        vecs.push_back('{a:32'h80000000, b:32'h3F800000, res:32'h80000000, flg:4'b0000, lat:1});
        vecs.push_back('{a:32'h3F800000, b:32'h3F800000, res:32'h3F800000, flg:4'b0000, lat:LAT});

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, r, f, lat);
            chk($sformatf("vec%0d_result", i), r,        vecs[i].res);
            chk($sformatf("vec%0d_flags",  i), 32'(f),   32'(vecs[i].flg));
            chk($sformatf("vec%0d_lat",    i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure with ignored operands while busy.
        @(negedge clk);
        float_a = 32'h3FC00000; float_b = 32'h3FC00000;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 200);
        chk("bp_lat", 32'(n), 32'(LAT));
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_valid%0d", k),  32'(out_valid), 32'd1);
            chk($sformatf("bp_result%0d", k), result,         32'h40100000);
            if (k >= 3 && k < 6) begin
                float_a = 32'h40000000; float_b = 32'h40400000; in_valid = 1'b1;
                chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready",  32'(in_ready),  32'd1);
        chk("drain_flags",     32'(flags),     32'h0);

        // Reset in the middle of MUL.
        @(negedge clk);
        float_a = 32'h40E00000; float_b = 32'hC0400000; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("midrst_no_output", 32'(saw), 32'd0);
        run_op(32'h40000000, 32'h40400000, 0, r, f, lat);
        chk("postrst_result", r,        32'h40C00000);
        chk("postrst_flags",  32'(f),   32'h0);
        chk("postrst_lat",    32'(lat), 32'(LAT));

        // Randomized operands with random output stalls.
        for (int i = 0; i < 60; i++) begin
            ra = rnd_fp();
            rb = rnd_fp();
            st = int'($urandom_range(0, 3));
            m  = model(ra, rb);
            run_op(ra, rb, st, r, f, lat);
            chk($sformatf("rnd%0d_result %h*%h", i, ra, rb), r, m[31:0]);
            chk($sformatf("rnd%0d_flags %h*%h", i, ra, rb), 32'(f), 32'(m[35:32]));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), is_spec(ra, rb) ? 32'd1 : 32'(LAT));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
